line_delay_ctrl: RTL and testbench

LINE_DELAY_CTRL -- requirements
Module: line_delay_ctrl

---
 rtl/line_delay_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_line_delay_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_delay_ctrl.sv
// -----------------------------------------------------------------------------
// line_delay_ctrl
// Pairs every incoming pixel with the pixel at the same column of the previous
// line. The line memory sits outside this block and is reached through a
// simple write port and a read port with 1-cycle registered read latency.
// The memory is read-before-write on the same address.
//
// Optional build macro: LINE_DELAY_ZERO_PAD_EN
//   defined   -> row-0 pixels report out_up = 0
//   undefined -> row-0 pixels report out_up = out_cur (edge replication)
// -----------------------------------------------------------------------------
module line_delay_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int ADDR_BIT = 10,
    parameter int DATA_BIT = 8
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [DATA_BIT-1:0] in_data,
    output logic                out_valid,
    output logic [DATA_BIT-1:0] out_cur,
    output logic [DATA_BIT-1:0] out_up,
    output logic                out_eol,
    output logic                out_eof,
    output logic                err_sync,
    output logic                mem_wr_en,
    output logic [ADDR_BIT-1:0] mem_wr_addr,
    output logic [DATA_BIT-1:0] mem_wr_data,
    output logic                mem_rd_en,
    output logic [ADDR_BIT-1:0] mem_rd_addr,
    input  logic [DATA_BIT-1:0] mem_rd_data
);

    localparam int                  ROW_BIT  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_BIT-1:0] LAST_COL = ADDR_BIT'(IMG_W - 1);
    localparam logic [ROW_BIT-1:0]  LAST_ROW = ROW_BIT'(IMG_H - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_BIT-1:0] col;
    logic [ADDR_BIT-1:0] col_nxt;
    logic [ROW_BIT-1:0]  row;
    logic [ROW_BIT-1:0]  row_nxt;

    // Position the pixel of this cycle is accepted at; a sof forces (0,0).
    logic [ADDR_BIT-1:0] acc_col;
    logic [ROW_BIT-1:0]  acc_row;
    logic                accept;
    logic                acc_eol;
    logic                acc_eof;
    logic                err_nxt;

    // Set while the pixel on the output stage came from row 1 or later, so
    // its upper neighbour is taken from the line memory.
    logic                up_from_mem;
    logic [DATA_BIT-1:0] up_sel;
    logic [DATA_BIT-1:0] up_hold;

    // State and position counters; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    // Accept/drop decision, framing error detection and counter advance.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        accept    = 1'b0;
        err_nxt   = 1'b0;
        acc_col   = col;
        acc_row   = row;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        accept  = 1'b1;
                        acc_col = '0;
                        acc_row = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_sof) begin
                        err_nxt = 1'b1;
                        acc_col = '0;
                        acc_row = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        acc_eol = accept && (acc_col == LAST_COL);
        acc_eof = acc_eol && (acc_row == LAST_ROW);

        if (accept) begin
            if (acc_eof) begin
                state_nxt = IDLE;
                col_nxt   = '0;
                row_nxt   = '0;
            end else if (acc_eol) begin
                state_nxt = ACTIVE;
                col_nxt   = '0;
                row_nxt   = acc_row + ROW_BIT'(1);
            end else begin
                state_nxt = ACTIVE;
                col_nxt   = acc_col + ADDR_BIT'(1);
                row_nxt   = acc_row;
            end
        end
    end

    // Line-memory port: write the new pixel and fetch the old one at the same
    // column in the same cycle; everything is held quiet while in reset.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_addr = '0;
        mem_rd_addr = '0;
        mem_wr_data = '0;
        if (accept && rst_b) begin
            mem_wr_en   = 1'b1;
            mem_rd_en   = 1'b1;
            mem_wr_addr = acc_col;
            mem_rd_addr = acc_col;
            mem_wr_data = in_data;
        end
    end

    // Output stage, one cycle behind the accept cycle to line up with the
    // registered memory read.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid   <= 1'b0;
            out_cur     <= '0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
            err_sync    <= 1'b0;
            up_from_mem <= 1'b0;
        end else begin
            out_valid <= accept;
            err_sync  <= err_nxt;
            out_eol   <= acc_eol;
            out_eof   <= acc_eof;
            if (accept) begin
                out_cur     <= in_data;
                up_from_mem <= (acc_row != '0);
            end
        end
    end

    // Upper-neighbour selection; row 0 never shows stale memory contents.
    always_comb begin
        up_sel = mem_rd_data;
        if (!up_from_mem) begin
`ifdef LINE_DELAY_ZERO_PAD_EN
            up_sel = '0;
`else
            up_sel = out_cur;
`endif
        end
    end

    // Remember the last presented out_up so it stays put across input gaps
    // even if the memory read data moves.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            up_hold <= '0;
        end else if (out_valid) begin
            up_hold <= up_sel;
        end
    end

    assign out_up = out_valid ? up_sel : up_hold;

endmodule

// File: tb/tb_line_delay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_delay_ctrl
// Self-checking bench for line_delay_ctrl with a small 4x3 image. The
// reference model tracks the frame as a linear pixel index and keeps the
// most recent pixel of each column, deriving row/col with division.
// Honours LINE_DELAY_ZERO_PAD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_line_delay_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AB = 3;
    localparam int DB = 8;

    logic          clk;
    logic          rst_b;
    logic          in_valid;
    logic          in_sof;
    logic [DB-1:0] in_data;
    logic          out_valid;
    logic [DB-1:0] out_cur;
    logic [DB-1:0] out_up;
    logic          out_eol;
    logic          out_eof;
    logic          err_sync;
    logic          mem_wr_en;
    logic [AB-1:0] mem_wr_addr;
    logic [DB-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AB-1:0] mem_rd_addr;
    logic [DB-1:0] mem_rd_data;

    logic [DB-1:0] line_mem [2**AB];

    int checks   = 0;
    int failures = 0;

    // Model state
    bit            m_active;
    int            m_pos;
    logic [DB-1:0] m_line [W];
    bit            e_valid;
    bit            e_err;
    bit            e_eol;
    bit            e_eof;
    logic [DB-1:0] e_cur;
    logic [DB-1:0] e_up;
    int            e_col;

    line_delay_ctrl #(
        .IMG_W   (W),
        .IMG_H   (H),
        .ADDR_BIT(AB),
        .DATA_BIT(DB)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_cur    (out_cur),
        .out_up     (out_up),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .err_sync   (err_sync),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line memory: registered read, read-before-write on the same address.
    initial begin
        for (int i = 0; i < 2**AB; i++) line_mem[i] = '0;
        mem_rd_data = '0;
    end
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= line_mem[mem_rd_addr];
        if (mem_wr_en) line_mem[mem_wr_addr] <= mem_wr_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic applyStimulus(input bit v, input bit s, input logic [DB-1:0] d);
        int r;
        in_valid = v;
        in_sof   = s;
        in_data  = d;

        e_valid = 1'b0;
        e_err   = 1'b0;
        if (v) begin
            if (!m_active) begin
                if (s) begin
                    e_valid = 1'b1;
                    m_pos   = 0;
                end else begin
                    e_err = 1'b1;
                end
            end else begin
                e_valid = 1'b1;
                if (s) begin
                    e_err = 1'b1;
                    m_pos = 0;
                end
            end
        end

        e_eol = 1'b0;
        e_eof = 1'b0;
        e_col = 0;
        if (e_valid) begin
            r     = m_pos / W;
            e_col = m_pos % W;
            e_cur = d;
            if (r > 0) e_up = m_line[e_col];
`ifdef LINE_DELAY_ZERO_PAD_EN
            else e_up = '0;
`else
            else e_up = d;
`endif
            m_line[e_col] = d;
            e_eol = (e_col == W - 1);
            e_eof = (m_pos == W * H - 1);
            if (e_eof) begin
                m_active = 1'b0;
                m_pos    = 0;
            end else begin
                m_active = 1'b1;
                m_pos++;
            end
        end

        #1;
        checkOutput("mem_wr_en", mem_wr_en, e_valid);
        checkOutput("mem_rd_en", mem_rd_en, e_valid);
        if (e_valid) begin
            checkOutput("mem_wr_addr", mem_wr_addr, e_col);
            checkOutput("mem_rd_addr", mem_rd_addr, e_col);
            checkOutput("mem_wr_data", mem_wr_data, d);
        end

        @(negedge clk);
        checkOutput("out_valid", out_valid, e_valid);
        checkOutput("err_sync", err_sync, e_err);
        checkOutput("out_cur", out_cur, e_cur);
        checkOutput("out_up", out_up, e_up);
        checkOutput("out_eol", out_eol, e_eol);
        checkOutput("out_eof", out_eof, e_eof);
    endtask

    // Asynchronous reset pulse in the middle of a cycle, with a sof pixel
    // presented so the memory port gating is exercised.
    task automatic applyReset();
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 8'hA5;
        #2 rst_b = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_cur", out_cur, 0);
        checkOutput("rst_out_up", out_up, 0);
        checkOutput("rst_out_eol", out_eol, 0);
        checkOutput("rst_out_eof", out_eof, 0);
        checkOutput("rst_err_sync", err_sync, 0);
        checkOutput("rst_mem_wr_en", mem_wr_en, 0);
        checkOutput("rst_mem_rd_en", mem_rd_en, 0);
        checkOutput("rst_mem_wr_addr", mem_wr_addr, 0);
        checkOutput("rst_mem_rd_addr", mem_rd_addr, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_b    = 1'b1;
        m_active = 1'b0;
        m_pos    = 0;
        e_cur    = '0;
        e_up     = '0;
    endtask

    initial begin
        bit v;
        bit s;
        rst_b    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        m_active = 1'b0;
        m_pos    = 0;
        e_cur    = '0;
        e_up     = '0;
        for (int i = 0; i < W; i++) m_line[i] = '0;

        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        checkOutput("por_out_valid", out_valid, 0);
        checkOutput("por_out_up", out_up, 0);
        checkOutput("por_err_sync", err_sync, 0);
        rst_b = 1'b1;
        @(negedge clk);

        // Continuous frame 1..12
        for (int i = 1; i <= W * H; i++) applyStimulus(1'b1, i == 1, DB'(i));
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Same frame with in_valid toggling every other cycle
        for (int i = 1; i <= W * H; i++) begin
            applyStimulus(1'b1, i == 1, DB'(i));
            applyStimulus(1'b0, 1'b0, DB'($urandom));
        end

        // Stray pixels while idle, then a normal frame
        applyStimulus(1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b0, 8'h66);
        for (int i = 1; i <= W * H; i++) applyStimulus(1'b1, i == 1, DB'(i + 16));

        // Restart by sof at pixel 6, then 11 more pixels to close the frame
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, i == 1, DB'(i + 32));
        for (int i = 6; i <= 17; i++) applyStimulus(1'b1, i == 6, DB'(i + 32));
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Reset during row 1, then a fresh frame
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, i == 1, DB'(i + 64));
        applyReset();
        applyStimulus(1'b1, 1'b0, 8'h77);
        for (int i = 1; i <= W * H; i++) applyStimulus(1'b1, i == 1, DB'(i + 96));

        // Random traffic with gaps, stray pixels and occasional early sof
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            if (!m_active) s = ($urandom_range(0, 4) != 0);
            else           s = ($urandom_range(0, 40) == 0);
            applyStimulus(v, s, DB'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
